// File: rtl/tft_pattern_gen_if.sv
// Video-side bundle of the TFT pattern generator: run controls in, panel timing and pixels out.
// master = generator, slave = panel / test side.
interface tft_pattern_gen_if #(
  parameter int CNT_W = 11
);
  logic             en;
  logic [1:0]       mode_sel;
  logic [15:0]      solid_color;
  logic [15:0]      rgb;
  logic             hsync;
  logic             vsync;
  logic             tft_de;
  logic             tft_bl;
  logic [CNT_W-1:0] pix_x;
  logic [CNT_W-1:0] pix_y;
  logic             frame_start;

  modport master (
    input  en, mode_sel, solid_color,
    output rgb, hsync, vsync, tft_de, tft_bl, pix_x, pix_y, frame_start
  );
  modport slave (
    output en, mode_sel, solid_color,
    input  rgb, hsync, vsync, tft_de, tft_bl, pix_x, pix_y, frame_start
  );
endinterface

// File: rtl/tft_pattern_gen.sv
// Parametrised TFT timing generator with colorbar / checker / gray ramp / solid patterns.
// Optional macro TFT_SCROLL_EN: colorbars scroll left one pixel per frame.
module tft_pattern_gen #(
  parameter int H_SYNC     = 41,
  parameter int H_BACK     = 2,
  parameter int H_VALID    = 480,
  parameter int H_FRONT    = 2,
  parameter int V_SYNC     = 10,
  parameter int V_BACK     = 2,
  parameter int V_VALID    = 272,
  parameter int V_FRONT    = 2,
  parameter int CNT_W      = 11,
  parameter int CHECK_LOG2 = 5
) (
  input  logic               tft_clk,
  input  logic               sys_rst,
  tft_pattern_gen_if.master  vif
);
  localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SW   = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SW   = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_ACT0 = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] H_ACT1 = CNT_W'(H_SYNC + H_BACK + H_VALID);
  localparam logic [CNT_W-1:0] V_ACT0 = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] V_ACT1 = CNT_W'(V_SYNC + V_BACK + V_VALID);
  localparam logic [CNT_W-1:0] BAR_W  = CNT_W'(H_VALID / 8);

  logic [CNT_W-1:0] cnt_h, cnt_v;
  logic [1:0]       sh_mode;
  logic [15:0]      sh_color;
  logic [15:0]      frame_cnt;

  logic             bound, active;
  logic [CNT_W-1:0] x, y, bx;
  logic [1:0]       eff_mode;
  logic [15:0]      eff_color, eff_fcnt, pat;
  logic [2:0]       bar;

  // On the boundary cycle the freshly sampled controls apply immediately, so the
  // frame being started never sees the previous frame's settings.
  always_comb begin
    bound     = (cnt_h == '0) && (cnt_v == '0);
    active    = (cnt_h >= H_ACT0) && (cnt_h < H_ACT1) && (cnt_v >= V_ACT0) && (cnt_v < V_ACT1);
    x         = active ? cnt_h - H_ACT0 : '0;
    y         = active ? cnt_v - V_ACT0 : '0;
    eff_mode  = bound ? vif.mode_sel    : sh_mode;
    eff_color = bound ? vif.solid_color : sh_color;
    eff_fcnt  = bound ? frame_cnt + 16'd1 : frame_cnt;
`ifdef TFT_SCROLL_EN
    bx = CNT_W'((17'(x) + 17'(eff_fcnt)) % 17'(H_VALID));
`else
    bx = x;
`endif
    bar = 3'(bx / BAR_W);
    pat = 16'h0000;
    case (eff_mode)
      2'd0: case (bar)
        3'd0: pat = 16'hFFFF;
        3'd1: pat = 16'hFFE0;
        3'd2: pat = 16'h07FF;
        3'd3: pat = 16'h07E0;
        3'd4: pat = 16'hF81F;
        3'd5: pat = 16'hF800;
        3'd6: pat = 16'h001F;
        default: pat = 16'h0000;
      endcase
      2'd1: pat = (x[CHECK_LOG2] ^ y[CHECK_LOG2]) ? 16'hFFFF : 16'h0000;
      2'd2: pat = {x[4:0], x[4:0], 1'b0, x[4:0]};
      default: pat = eff_color;
    endcase
  end

  always_ff @(posedge tft_clk) begin
    if (sys_rst) begin
      cnt_h           <= '0;
      cnt_v           <= '0;
      sh_mode         <= '0;
      sh_color        <= '0;
      frame_cnt       <= '0;
      vif.rgb         <= '0;
      vif.hsync       <= 1'b0;
      vif.vsync       <= 1'b0;
      vif.tft_de      <= 1'b0;
      vif.tft_bl      <= 1'b0;
      vif.pix_x       <= '0;
      vif.pix_y       <= '0;
      vif.frame_start <= 1'b0;
    end else if (!vif.en) begin
      cnt_h           <= '0;
      cnt_v           <= '0;
      vif.rgb         <= '0;
      vif.hsync       <= 1'b0;
      vif.vsync       <= 1'b0;
      vif.tft_de      <= 1'b0;
      vif.tft_bl      <= 1'b0;
      vif.pix_x       <= '0;
      vif.pix_y       <= '0;
      vif.frame_start <= 1'b0;
    end else begin
      if (cnt_h == H_LAST) begin
        cnt_h <= '0;
        cnt_v <= (cnt_v == V_LAST) ? '0 : cnt_v + 1'b1;
      end else begin
        cnt_h <= cnt_h + 1'b1;
      end
      if (bound) begin
        sh_mode   <= vif.mode_sel;
        sh_color  <= vif.solid_color;
        frame_cnt <= eff_fcnt;
      end
      vif.rgb         <= active ? pat : 16'h0000;
      vif.hsync       <= cnt_h < H_SW;
      vif.vsync       <= cnt_v < V_SW;
      vif.tft_de      <= active;
      vif.tft_bl      <= 1'b1;
      vif.pix_x       <= x;
      vif.pix_y       <= y;
      vif.frame_start <= bound;
    end
  end
endmodule

// File: doc/tft_pattern_gen.md
# tft_pattern_gen

Parametrised TFT timing generator and test-pattern engine, the successor to the fixed 480x272 colorbar path. It runs entirely in the pixel-clock domain and produces hsync/vsync/DE and RGB565 pixel data for any panel geometry set by parameters. Four run-time patterns are available: colorbar, checkerboard, gray ramp and solid colour. Pattern changes take effect only at frame boundaries so the panel never shows a torn frame.

## Interface
Parameters:
- `H_SYNC`, 41: hsync pulse width, pixels
- `H_BACK`, 2: horizontal back porch
- `H_VALID`, 480: active pixels per line; must be a multiple of 8
- `H_FRONT`, 2: horizontal front porch
- `V_SYNC`, 10: vsync pulse width, lines
- `V_BACK`, 2: vertical back porch
- `V_VALID`, 272: active lines
- `V_FRONT`, 2: vertical front porch
- `CNT_W`, 11: counter and coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
- `CHECK_LOG2`, 5: checkerboard square size, 2^CHECK_LOG2 pixels

Ports:
- `tft_clk` in 1: pixel clock; all logic on its rising edge
- `sys_rst` in 1: synchronous, active-high reset
- `en` in 1: run enable
- `mode_sel` in 2: 0 colorbar, 1 checkerboard, 2 gray ramp, 3 solid
- `solid_color` in 16: RGB565 value for mode 3
- `rgb` out 16: pixel data, RGB565
- `hsync` out 1: high during the horizontal sync pulse
- `vsync` out 1: high during the vertical sync pulse
- `tft_de` out 1: data enable, high during active area
- `tft_bl` out 1: backlight, equals registered `en`
- `pix_x` out CNT_W: active-area column; 0 outside active area
- `pix_y` out CNT_W: active-area row; 0 outside active area
- `frame_start` out 1: one-cycle pulse on the first pixel of each frame

## Operation
- Totals: H_TOTAL = H_SYNC+H_BACK+H_VALID+H_FRONT; V_TOTAL likewise.
- `cnt_h` counts 0..H_TOTAL-1 and wraps to 0. `cnt_v` increments when `cnt_h` wraps and itself wraps at V_TOTAL-1.
- Sync region: hsync when cnt_h < H_SYNC; vsync when cnt_v < V_SYNC.
- Active region: cnt_h in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_VALID-1] and cnt_v in the corresponding vertical range.
- Inside active region: x = cnt_h-(H_SYNC+H_BACK), y = cnt_v-(V_SYNC+V_BACK).
- Frame boundary: cnt_h==0 && cnt_v==0. At this point `mode_sel` and `solid_color` are copied into shadow registers, the 16-bit `frame_cnt` increments (wrapping), and `frame_start` pulses.
- Patterns use shadow values only:
  - Mode 0: 8 bars, each H_VALID/8 wide. Bar index = bx/(H_VALID/8). Left to right: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - Mode 1: FFFF when (x>>CHECK_LOG2)[0] ^ (y>>CHECK_LOG2)[0] is 1, else 0000.
  - Mode 2: g = x[4:0]; rgb = {g, g, 1'b0, g}. The ramp repeats every 32 px.
  - Mode 3: shadow `solid_color`.
- Outside the active region, rgb = 0000.
- `en`=0: counters are held at 0, all outputs are 0, and no shadow update happens. When `en` returns to 1, the first counted cycle is a frame boundary.

## Timing
- Reset values: all outputs 0, counters 0, shadow mode 0, shadow colour 0000, frame_cnt 0.
- Latency: every output is registered exactly 1 cycle after the counter state it describes. rgb, de, hsync, vsync, pix_x and pix_y are mutually aligned.
- frame_start is high on the same output cycle as the first pixel of the frame (counters 0,0).
- A `mode_sel` change mid-frame has no visible effect until the first active pixel after the next frame boundary.
- A mode change sampled exactly on the boundary cycle applies to that frame.
- `sys_rst` mid-line: on the next edge, counters, outputs and shadows return to reset values. Counting restarts at 0,0 the following cycle.

## Configuration
- `TFT_SCROLL_EN` defined: in mode 0, bx = (x + frame_cnt) mod H_VALID, so the bars scroll left 1 pixel per frame.
- `TFT_SCROLL_EN` not defined: bx = x, giving static bars, and `frame_cnt` is not used for pattern generation (frame_start still operates).

## Test plan
- Default params, en=1, mode 0: the first active line carries FFFF for x 0–59, FFE0 for x 60–119, and so on to 0000 for x 420–479. hsync is high for 41 cycles per 525-cycle line. vsync is high for 10 of 286 lines.
- Mode 1, CHECK_LOG2=5: (x,y)=(0,0) gives 0000; (32,0) gives FFFF; (32,32) gives 0000. tft_de is high for exactly 480×272 cycles per frame.
- Switch mode_sel 0→3 with solid_color=F800 mid-frame: the rest of that frame remains colorbar. The next frame is all F800 in the active area and 0000 in blanking.
- Drive en=0 for 100 cycles mid-line: all outputs are 0. On re-enable, frame_start pulses 1 cycle after en rises and pix_x/pix_y restart from 0.
- Assert sys_rst at cnt_h=200: outputs are 0 on the next edge and the shadow mode returns to 0.
- With TFT_SCROLL_EN, frame 3: x=57 is FFE0 (bx=60) and x=477 is FFFF (bx=0 after wrap).
